// File: rtl/x4xx_qsfp_mon_pkg.sv
// Shared register offsets, lane stride, global addresses and lane FSM encoding
// for the QSFP link monitor.
package x4xx_qsfp_mon_pkg;

  localparam logic [11:0] LANE_STRIDE     = 12'h020;
  localparam logic [4:0]  OFF_STATUS      = 5'h00;
  localparam logic [4:0]  OFF_RX_PKTS     = 5'h04;
  localparam logic [4:0]  OFF_TX_PKTS     = 5'h08;
  localparam logic [4:0]  OFF_LINK_DROPS  = 5'h0C;
  localparam logic [4:0]  OFF_CTRL        = 5'h10;

  localparam logic [11:0] GLB_BASE        = 12'h100;
  localparam logic [11:0] ADDR_IRQ_STATUS = GLB_BASE + 12'h000;
  localparam logic [11:0] ADDR_IRQ_MASK   = GLB_BASE + 12'h004;
  localparam logic [11:0] ADDR_INFO       = GLB_BASE + 12'h008;

  typedef enum logic [1:0] {
    LS_DOWN = 2'd0,
    LS_QUAL = 2'd1,
    LS_UP   = 2'd2
  } lane_state_t;

  // Byte address of a lane register
  function automatic logic [11:0] lane_addr(input int lane, input logic [4:0] off);
    return (12'(lane) << 5) | {7'b0, off};
  endfunction

endpackage

// File: rtl/x4xx_qsfp_lane_mon.sv
// One QSFP lane: link debounce FSM, activity stretcher and saturating
// RX/TX/link-drop counters.
module x4xx_qsfp_lane_mon
  import x4xx_qsfp_mon_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int ACT_HOLD_CYC = 2500000,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_phy_link_up,
  input  logic             i_rx_pkt,
  input  logic             i_tx_pkt,
  input  logic             i_clr,
  output logic             o_link_up,
  output logic             o_activity,
  output logic             o_link_chg,
  output logic [CNT_W-1:0] o_rx_pkts,
  output logic [CNT_W-1:0] o_tx_pkts,
  output logic [CNT_W-1:0] o_link_drops
);

  localparam int QW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = (ACT_HOLD_CYC < 2) ? 1 : $clog2(ACT_HOLD_CYC + 1);
  localparam logic [QW-1:0] QUAL_MAX = QW'(DEBOUNCE_CYC);
  localparam logic [HW-1:0] HOLD_MAX = HW'(ACT_HOLD_CYC);

  lane_state_t     r_state;
  lane_state_t     w_state_nxt;
  logic [QW-1:0]   r_qual_cnt;
  logic [HW-1:0]   r_hold;
  logic [HW-1:0]   w_hold_nxt;
  logic            r_link_up;
  logic            r_activity;
  logic            w_link_up_nxt;
  logic            w_drop;
  logic [CNT_W-1:0] r_rx_pkts;
  logic [CNT_W-1:0] r_tx_pkts;
  logic [CNT_W-1:0] r_link_drops;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= LS_DOWN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LS_DOWN: if (i_phy_link_up) w_state_nxt = LS_QUAL;
      LS_QUAL: begin
        if (!i_phy_link_up)               w_state_nxt = LS_DOWN;
        else if (r_qual_cnt >= QUAL_MAX)  w_state_nxt = LS_UP;
      end
      LS_UP:   if (!i_phy_link_up) w_state_nxt = LS_DOWN;
      default: w_state_nxt = LS_DOWN;
    endcase
  end

  always_comb begin
    w_link_up_nxt = (w_state_nxt == LS_UP);
    w_drop        = (r_state == LS_UP) && (w_state_nxt == LS_DOWN);
    o_link_chg    = (w_link_up_nxt != r_link_up);
  end

  // Hold counter reloads on any packet strobe, otherwise drains to zero
  always_comb begin
    if (i_rx_pkt || i_tx_pkt) w_hold_nxt = HOLD_MAX;
    else if (r_hold != '0)    w_hold_nxt = r_hold - HW'(1);
    else                      w_hold_nxt = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_qual_cnt <= '0;
      r_hold     <= '0;
      r_link_up  <= 1'b0;
      r_activity <= 1'b0;
    end else begin
      if (w_state_nxt == LS_QUAL)
        r_qual_cnt <= (r_state == LS_QUAL) ? r_qual_cnt + QW'(1) : QW'(1);
      else
        r_qual_cnt <= '0;
      r_hold     <= w_hold_nxt;
      r_link_up  <= w_link_up_nxt;
      r_activity <= (w_hold_nxt != '0);
    end
  end

  // Clear takes priority over a same-cycle increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_pkts    <= '0;
      r_tx_pkts    <= '0;
      r_link_drops <= '0;
    end else if (i_clr) begin
      r_rx_pkts    <= '0;
      r_tx_pkts    <= '0;
      r_link_drops <= '0;
    end else begin
      if (i_rx_pkt) r_rx_pkts    <= sat_inc(r_rx_pkts);
      if (i_tx_pkt) r_tx_pkts    <= sat_inc(r_tx_pkts);
      if (w_drop)   r_link_drops <= sat_inc(r_link_drops);
    end
  end

  assign o_link_up    = r_link_up;
  assign o_activity   = r_activity;
  assign o_rx_pkts    = r_rx_pkts;
  assign o_tx_pkts    = r_tx_pkts;
  assign o_link_drops = r_link_drops;

endmodule

// File: rtl/x4xx_qsfp_link_monitor.sv
// N-lane QSFP link/activity monitor: per-lane monitors plus register decode,
// maskable link-change interrupt and port_info packing.
module x4xx_qsfp_link_monitor
  import x4xx_qsfp_mon_pkg::*;
#(
  parameter int         NUM_LANES    = 4,
  parameter int         DEBOUNCE_CYC = 1000,
  parameter int         ACT_HOLD_CYC = 2500000,
  parameter int         CNT_W        = 32,
  parameter logic [7:0] PORTNUM      = 8'd0
) (
  input  logic                     bus_clk,
  input  logic                     areset,
  input  logic [NUM_LANES-1:0]     phy_link_up,
  input  logic [NUM_LANES-1:0]     rx_pkt,
  input  logic [NUM_LANES-1:0]     tx_pkt,
  input  logic                     reg_wr_req,
  input  logic [11:0]              reg_wr_addr,
  input  logic [31:0]              reg_wr_data,
  input  logic                     reg_rd_req,
  input  logic [11:0]              reg_rd_addr,
  output logic                     reg_rd_resp,
  output logic [31:0]              reg_rd_data,
  output logic [NUM_LANES-1:0]     link_up,
  output logic [NUM_LANES-1:0]     activity,
  output logic [32*NUM_LANES-1:0]  port_info,
  output logic                     irq
);

  logic [CNT_W-1:0]     w_rx_cnt   [NUM_LANES];
  logic [CNT_W-1:0]     w_tx_cnt   [NUM_LANES];
  logic [CNT_W-1:0]     w_drop_cnt [NUM_LANES];
  logic [NUM_LANES-1:0] w_chg;
  logic [NUM_LANES-1:0] w_clr;
  logic [NUM_LANES-1:0] w_w1c;
  logic [NUM_LANES-1:0] r_irq_status;
  logic [NUM_LANES-1:0] r_irq_mask;
  logic                 r_irq;
  logic                 r_rd_resp;
  logic [31:0]          r_rd_data;
  logic [31:0]          w_rd_data;
  logic                 w_unused;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      x4xx_qsfp_lane_mon #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .ACT_HOLD_CYC (ACT_HOLD_CYC),
        .CNT_W        (CNT_W)
      ) u_lane (
        .i_clk         (bus_clk),
        .i_rst         (areset),
        .i_phy_link_up (phy_link_up[g]),
        .i_rx_pkt      (rx_pkt[g]),
        .i_tx_pkt      (tx_pkt[g]),
        .i_clr         (w_clr[g]),
        .o_link_up     (link_up[g]),
        .o_activity    (activity[g]),
        .o_link_chg    (w_chg[g]),
        .o_rx_pkts     (w_rx_cnt[g]),
        .o_tx_pkts     (w_tx_cnt[g]),
        .o_link_drops  (w_drop_cnt[g])
      );
    end
  endgenerate

  always_comb begin
    w_clr = '0;
    for (int l = 0; l < NUM_LANES; l++)
      w_clr[l] = reg_wr_req && (reg_wr_addr == lane_addr(l, OFF_CTRL)) && reg_wr_data[0];
  end

  assign w_w1c = (reg_wr_req && reg_wr_addr == ADDR_IRQ_STATUS) ?
                 reg_wr_data[NUM_LANES-1:0] : '0;

  // A new link change in the same cycle as its W1C keeps the bit set
  always_ff @(posedge bus_clk or posedge areset) begin
    if (areset) begin
      r_irq_status <= '0;
      r_irq_mask   <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_status <= (r_irq_status & ~w_w1c) | w_chg;
      if (reg_wr_req && reg_wr_addr == ADDR_IRQ_MASK)
        r_irq_mask <= reg_wr_data[NUM_LANES-1:0];
      r_irq <= |(r_irq_status & r_irq_mask);
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (reg_rd_addr[11:8] == 4'h0) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (reg_rd_addr[7:5] == 3'(l)) begin
          case (reg_rd_addr[4:0])
            OFF_STATUS: begin
              w_rd_data[15:8] = 8'(l);
              w_rd_data[2]    = phy_link_up[l];
              w_rd_data[1]    = activity[l];
              w_rd_data[0]    = link_up[l];
            end
            OFF_RX_PKTS:    w_rd_data = 32'(w_rx_cnt[l]);
            OFF_TX_PKTS:    w_rd_data = 32'(w_tx_cnt[l]);
            OFF_LINK_DROPS: w_rd_data = 32'(w_drop_cnt[l]);
            default:        w_rd_data = '0;
          endcase
        end
      end
    end else begin
      case (reg_rd_addr)
        ADDR_IRQ_STATUS: w_rd_data[NUM_LANES-1:0] = r_irq_status;
        ADDR_IRQ_MASK:   w_rd_data[NUM_LANES-1:0] = r_irq_mask;
        ADDR_INFO:       w_rd_data = {16'h0, PORTNUM, 4'h0, 4'(NUM_LANES)};
        default:         w_rd_data = '0;
      endcase
    end
  end

  // Read data is taken from pre-write state, so a same-cycle write is not seen
  always_ff @(posedge bus_clk or posedge areset) begin
    if (areset) begin
      r_rd_resp <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_resp <= reg_rd_req;
      if (reg_rd_req) r_rd_data <= w_rd_data;
    end
  end

  always_comb begin
    port_info = '0;
    for (int l = 0; l < NUM_LANES; l++)
      port_info[32*l +: 32] = {PORTNUM, 8'(l), 14'b0, activity[l], link_up[l]};
  end

  assign w_unused    = ^reg_wr_data;
  assign reg_rd_resp = r_rd_resp;
  assign reg_rd_data = r_rd_data;
  assign irq         = r_irq;

endmodule
